// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: instruction-memory channel between the fetch unit and imem.
//   imem_req_valid/imem_req_ready/imem_req_addr : in-order fetch requests (fetch -> memory)
//   imem_rsp_valid/imem_rsp_data                : in-order responses, no backpressure (memory -> fetch)
//   modport master: fetch unit side; modport slave: memory side.
interface ifu_prefetch_if #(parameter int XLEN = 64);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction-fetch unit with a DEPTH-entry prefetch queue and redirect flush.
//   clk, rst (async, active-low)
//   imem           : ifu_prefetch_if.master, request/response channel to instruction memory
//   redirect_valid, redirect_pc : new fetch target; flushes the queue and in-flight responses
//   inst_valid, inst_ready, inst, inst_pc : queue head presented to decode
//   perf_fetch_cnt, perf_stall_cnt : present only when IFU_PERF_CNT_EN is defined
module ifu_prefetch #(
    parameter int          XLEN   = 64,
    parameter logic [63:0] PC_RST = 64'h8000_0000,
    parameter int          DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ifu_prefetch_if.master        imem,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [XLEN-1:0]       inst_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]           perf_fetch_cnt,
    output logic [63:0]           perf_stall_cnt
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] RST_PC = PC_RST[XLEN-1:0];

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] rspPc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rdPtr;
    logic [AW-1:0]   wrPtr;
    logic [XLEN-1:0] pcMem   [DEPTH];
    logic [31:0]     instMem [DEPTH];

    logic [XLEN-1:0] redirPc;
    logic [CW:0]     inFlight;
    logic            reqFire;
    logic            push;
    logic            pop;
    logic [CW-1:0]   outstandingNext;

    always_comb begin
        redirPc = redirect_pc & ~XLEN'(3);
        // queued entries plus outstanding requests never exceed DEPTH, so a push can never overflow
        inFlight = {1'b0, count} + {1'b0, outstanding};
        imem.imem_req_valid = rst && !redirect_valid && (inFlight < (CW+1)'(DEPTH));
        imem.imem_req_addr = fetchPc;
        reqFire = imem.imem_req_valid && imem.imem_req_ready;
        inst_valid = count != '0;
        inst = inst_valid ? instMem[rdPtr] : '0;
        inst_pc = inst_valid ? pcMem[rdPtr] : '0;
        push = imem.imem_rsp_valid && (discard == '0) && !redirect_valid;
        pop = inst_valid && inst_ready && !redirect_valid;
        outstandingNext = outstanding + CW'(reqFire) - CW'(imem.imem_rsp_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc     <= RST_PC;
            rspPc       <= RST_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (redirect_valid) begin
                // every request still in flight after this cycle returns stale data
                fetchPc <= redirPc;
                rspPc   <= redirPc;
                discard <= outstandingNext;
                count   <= '0;
                rdPtr   <= '0;
                wrPtr   <= '0;
            end else begin
                if (reqFire)
                    fetchPc <= fetchPc + XLEN'(4);
                if (push) begin
                    rspPc <= rspPc + XLEN'(4);
                    wrPtr <= wrPtr + AW'(1);
                end
                if (pop)
                    rdPtr <= rdPtr + AW'(1);
                if (imem.imem_rsp_valid && discard != '0)
                    discard <= discard - CW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr]   <= rspPc;
            instMem[wrPtr] <= imem.imem_rsp_data;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop)
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (inst_ready && !inst_valid && !redirect_valid)
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: self-checking bench for ifu_prefetch with an in-order memory model and PC scoreboard.
//   Drives the memory side of ifu_prefetch_if, redirects and decode readiness; compares request
//   addresses and popped {inst_pc, inst} against expected streams. Checks perf counters when
//   IFU_PERF_CNT_EN is defined.
module tb_ifu_prefetch;
    localparam int          XLEN   = 64;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] PC_RST = 64'h8000_0000;

    typedef struct {
        logic [63:0] target;
        logic [63:0] expAddr;
        int          runCyc;
        bit          wraps;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ifu_prefetch_if #(.XLEN(XLEN)) bus ();

    ifu_prefetch #(.XLEN(XLEN), .PC_RST(PC_RST), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .imem(bus),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst && bus.imem_rsp_valid)
            assert (dut.outstanding != '0) else $error("protocol: memory response with nothing outstanding");

    int          errors = 0;
    int          checks = 0;
    logic        memReady;
    logic        rspEn;
    logic [63:0] memQ [$];
    logic [63:0] expQ [$];
    logic [63:0] modelPc;
    int          cyc = 0;
    int          reqCnt;
    int          popCnt;
    int          firstReqCyc;
    int          firstValidCyc;
    logic [63:0] firstReqAddr;
    logic [63:0] firstPopPc;
    logic        prevHeld;
    logic        sawZero;
    longint unsigned fetchExp;
    longint unsigned stallExp;
    vec_t        vecs [5];

    function automatic logic [31:0] instOf(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle: called just after a negedge, returns just after the next negedge.
    task automatic cycle();
        logic rspValid;
        logic reqFire;
        logic popFire;
        rspValid = rspEn && memQ.size() != 0;
        bus.imem_req_ready = memReady;
        bus.imem_rsp_valid = rspValid;
        if (rspValid)
            bus.imem_rsp_data = instOf(memQ[0]);
        else
            bus.imem_rsp_data = 32'h0;
        #1;
        reqFire = bus.imem_req_valid && bus.imem_req_ready;
        popFire = inst_valid && inst_ready && !redirect_valid;
        if (redirect_valid)
            check("req_valid_in_redirect", 64'(bus.imem_req_valid), 64'd0);
        else if (prevHeld)
            check("req_valid_held", 64'(bus.imem_req_valid), 64'd1);
        if (inst_valid && firstValidCyc < 0)
            firstValidCyc = cyc;
        if (popFire) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc %h want no entry", inst_pc);
            end else begin
                check("inst_pc", inst_pc, expQ[0]);
                check("inst", 64'(inst), 64'(instOf(expQ[0])));
                void'(expQ.pop_front());
            end
            if (popCnt == 0)
                firstPopPc = inst_pc;
            popCnt++;
            fetchExp++;
        end
        if (inst_ready && !inst_valid && !redirect_valid)
            stallExp++;
        if (rspValid)
            void'(memQ.pop_front());
        if (reqFire) begin
            check("req_addr", bus.imem_req_addr, modelPc);
            if (reqCnt == 0) begin
                firstReqAddr = bus.imem_req_addr;
                firstReqCyc = cyc;
            end
            if (bus.imem_req_addr == 64'h0)
                sawZero = 1'b1;
            reqCnt++;
            memQ.push_back(modelPc);
            expQ.push_back(modelPc);
            modelPc += 64'd4;
        end
        if (redirect_valid) begin
            expQ.delete();
            modelPc = redirect_pc & ~64'd3;
        end
        prevHeld = bus.imem_req_valid && !bus.imem_req_ready && !redirect_valid;
        @(negedge clk);
        cyc++;
    endtask

    task automatic doReset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        memReady = 1'b0;
        rspEn = 1'b0;
        inst_ready = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        #3;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
`ifdef IFU_PERF_CNT_EN
        check("rst_perf_fetch", perf_fetch_cnt, 64'd0);
        check("rst_perf_stall", perf_stall_cnt, 64'd0);
`endif
        @(negedge clk);
        memQ.delete();
        expQ.delete();
        modelPc = PC_RST;
        prevHeld = 1'b0;
        fetchExp = 0;
        stallExp = 0;
        rst = 1'b1;
    endtask

    task automatic arm();
        reqCnt = 0;
        popCnt = 0;
        firstValidCyc = -1;
        firstReqAddr = '1;
        firstPopPc = '1;
        sawZero = 1'b0;
    endtask

    initial begin
        vecs[0] = '{target: 64'hFFFF_FFFF_FFFF_FFFC, expAddr: 64'hFFFF_FFFF_FFFF_FFFC, runCyc: 10, wraps: 1'b1};
        vecs[1] = '{target: 64'h0000_0000_0000_1003, expAddr: 64'h0000_0000_0000_1000, runCyc: 8,  wraps: 1'b0};
        vecs[2] = '{target: 64'h0000_0000_0000_0002, expAddr: 64'h0000_0000_0000_0000, runCyc: 8,  wraps: 1'b0};
        vecs[3] = '{target: 64'h7FFF_FFFF_FFFF_FFFE, expAddr: 64'h7FFF_FFFF_FFFF_FFFC, runCyc: 8,  wraps: 1'b0};
        vecs[4] = '{target: 64'h8000_0000_0000_0105, expAddr: 64'h8000_0000_0000_0104, runCyc: 8,  wraps: 1'b0};
        @(negedge clk);
        doReset();

        // Streaming from reset with single-cycle memory
        arm();
        memReady = 1'b1;
        rspEn = 1'b1;
        inst_ready = 1'b1;
        repeat (12) cycle();
        check("first_req_addr", firstReqAddr, 64'h8000_0000);
        check("first_valid_latency", 64'(firstValidCyc - firstReqCyc), 64'd2);
        check("first_pop_pc", firstPopPc, 64'h8000_0000);
        check("stream_pops", 64'(popCnt), 64'd10);

        // Reset with a live queue, then decode stalled: credit caps requests at DEPTH
        doReset();
        arm();
        memReady = 1'b1;
        rspEn = 1'b1;
        repeat (10) cycle();
        check("credit_req_cnt", 64'(reqCnt), 64'(DEPTH));
        check("credit_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("credit_inst_valid", 64'(inst_valid), 64'd1);
        arm();
        inst_ready = 1'b1;
        repeat (10) cycle();
        check("resume_addr", firstReqAddr, 64'h8000_0010);
        check("resume_first_pop", firstPopPc, 64'h8000_0000);

        // Memory ready toggling each cycle
        arm();
        for (int i = 0; i < 16; i++) begin
            memReady = (i % 2) == 0;
            cycle();
        end
        check("toggle_req_cnt", 64'(reqCnt), 64'd8);
        memReady = 1'b1;

        // Redirect with 3 outstanding and 1 queued
        doReset();
        memReady = 1'b1;
        repeat (6) cycle();
        rspEn = 1'b1;
        memReady = 1'b0;
        cycle();
        rspEn = 1'b0;
        cycle();
        check("pre_redirect_inst_valid", 64'(inst_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0103;
        cycle();
        redirect_valid = 1'b0;
        check("flush_inst_valid", 64'(inst_valid), 64'd0);
        arm();
        memReady = 1'b1;
        rspEn = 1'b1;
        inst_ready = 1'b1;
        repeat (12) cycle();
        check("redir_first_req", firstReqAddr, 64'h8000_0100);
        check("redir_first_pop", firstPopPc, 64'h8000_0100);

        // Redirect coinciding with a response and a pop
        inst_ready = 1'b0;
        repeat (2) cycle();
        rspEn = 1'b0;
        repeat (2) cycle();
        check("rsp_pop_pre_inst_valid", 64'(inst_valid), 64'd1);
        rspEn = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        cycle();
        redirect_valid = 1'b0;
        check("rsp_pop_post_inst_valid", 64'(inst_valid), 64'd0);
        arm();
        repeat (10) cycle();
        check("rsp_pop_first_pop", firstPopPc, 64'h8000_0200);

        // Back-to-back redirects: the last target wins
        inst_ready = 1'b0;
        rspEn = 1'b0;
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc = 64'h9000_0000;
        cycle();
        rspEn = 1'b1;
        redirect_pc = 64'hA000_0008;
        cycle();
        redirect_valid = 1'b0;
        arm();
        inst_ready = 1'b1;
        repeat (12) cycle();
        check("b2b_first_req", firstReqAddr, 64'hA000_0008);
        check("b2b_first_pop", firstPopPc, 64'hA000_0008);

        // Table of redirect targets, including address wrap
        for (int i = 0; i < 5; i++) begin
            memReady = 1'b1;
            rspEn = 1'b1;
            inst_ready = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc = vecs[i].target;
            cycle();
            redirect_valid = 1'b0;
            arm();
            repeat (vecs[i].runCyc) cycle();
            check("vec_first_req", firstReqAddr, vecs[i].expAddr);
            check("vec_first_pop", firstPopPc, vecs[i].expAddr);
            if (vecs[i].wraps)
                check("vec_wrap_zero", 64'(sawZero), 64'd1);
        end

`ifdef IFU_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 64'(fetchExp));
        check("perf_stall_cnt", perf_stall_cnt, 64'(stallExp));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
